core_fetch_unit: RTL

Instruction fetch stage that produces the `instruction` / `pc_i` pair consumed by the decode/control unit. It issues word-aligned requests to instruction memory over a req/gnt/rvalid protocol and keeps up to DEPTH fetches in flight. Returned words and their PCs are buffered in a small FIFO and presented to decode with a valid/ready handshake. A redirect from execute (jump/branch) flushes the buffer and discards stale in-flight responses.

---
 rtl/core_fetch_unit_pkg.sv | 16 +
 rtl/core_fetch_unit_if.sv | 30 +++
 rtl/core_fetch_unit_fetch_fifo.sv | 63 ++++++
 rtl/core_fetch_unit.sv | 104 ++++++++++
 4 files changed

// File: rtl/core_fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage: memory widths, reset
// vector, the NOP presented while the buffer is empty, and counter sizing.
package core_fetch_unit_pkg;

   localparam int          MEM_ADDR_WIDTH = 32;
   localparam int          MEM_DATA_WIDTH = 32;
   localparam logic [31:0] RESET_VECTOR   = 32'h0000_0000;
   localparam logic [31:0] INSTR_NOP      = 32'h0000_0013;  // addi x0,x0,0
   localparam int          DEFAULT_DEPTH  = 2;

   // Counters must hold the value DEPTH itself, hence one bit above log2.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/core_fetch_unit_if.sv
// Bus bundles of the fetch stage: the instruction-memory request/response
// channel and the valid/ready channel towards decode.
import core_fetch_unit_pkg::*;

interface core_fetch_unit_imem_if #(
   parameter int ADDR_W = MEM_ADDR_WIDTH,
   parameter int DATA_W = MEM_DATA_WIDTH
);
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (output req, output addr, input gnt, input rvalid, input rdata);
   modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

interface core_fetch_unit_instr_if #(
   parameter int ADDR_W = MEM_ADDR_WIDTH,
   parameter int DATA_W = MEM_DATA_WIDTH
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] pc;

   modport master (output valid, output instr, output pc, input ready);
   modport slave  (input valid, input instr, input pc, output ready);
endinterface

// File: rtl/core_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO holding {pc, instruction} pairs; the head is read
// combinationally and a flush empties it, taking priority over push.
import core_fetch_unit_pkg::*;

module fetch_fifo #(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int WIDTH = 64,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_push;
   logic             do_pop;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == DEPTH_C);
   assign count   = count_reg;
   assign dout    = mem_reg[rd_ptr_reg];

   // A full FIFO may still take a push when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push && !flush && !rst) begin
         mem_reg[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/core_fetch_unit.sv
// Instruction fetch stage: keeps up to DEPTH word fetches in flight, buffers
// returned words with their PCs, and restarts cleanly on a redirect.
import core_fetch_unit_pkg::*;

module core_fetch_unit #(
   parameter int                ADDR_W   = MEM_ADDR_WIDTH,
   parameter int                DATA_W   = MEM_DATA_WIDTH,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VECTOR),
   parameter int                DEPTH    = DEFAULT_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     redirect,
   input  logic [ADDR_W-1:0]        redirect_pc,
   core_fetch_unit_imem_if.master   imem,
   core_fetch_unit_instr_if.master  dec
);

   localparam int              CW      = cnt_width(DEPTH);
   localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(4);

   logic [ADDR_W-1:0] fetch_pc_reg;
   logic [ADDR_W-1:0] resp_pc_reg;
   logic [CW-1:0]     outstanding_reg;
   logic [CW-1:0]     outstanding_next;
   logic [CW-1:0]     discard_reg;

   logic [ADDR_W-1:0]        target_pc;
   logic [CW-1:0]            fifo_count;
   logic                     fifo_empty;
   logic                     fifo_full;
   logic [ADDR_W+DATA_W-1:0] fifo_dout;
   logic [CW:0]              pending;
   logic                     pop;
   logic                     issue;
   logic                     rsp;
   logic                     push;

   assign target_pc = redirect_pc & ~ADDR_W'(3);
   assign pop       = !fifo_empty && dec.ready;

   // A slot freed by this cycle's pop is already available for a new request;
   // any granted word returns at least one cycle later, so the FIFO never overflows.
   assign pending   = {1'b0, outstanding_reg} + {1'b0, fifo_count} - (CW + 1)'(pop);

   assign imem.req  = !rst && !redirect && (pending < DEPTH_C) && (!fifo_full || pop);
   assign imem.addr = fetch_pc_reg;
   assign issue     = imem.req && imem.gnt;

   // A response with nothing outstanding is a leftover from before reset.
   assign rsp       = imem.rvalid && (outstanding_reg != '0);
   assign push      = rsp && !redirect && (discard_reg == '0);

   assign outstanding_next = outstanding_reg + CW'(issue) - CW'(rsp);

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_reg    <= RESET_PC;
         resp_pc_reg     <= RESET_PC;
         outstanding_reg <= '0;
         discard_reg     <= '0;
      end else begin
         outstanding_reg <= outstanding_next;
         if (redirect) begin
            fetch_pc_reg <= target_pc;
            resp_pc_reg  <= target_pc;
            discard_reg  <= outstanding_next;
         end else begin
            if (issue) begin
               fetch_pc_reg <= fetch_pc_reg + STEP;
            end
            if (rsp) begin
               if (discard_reg != '0) begin
                  discard_reg <= discard_reg - CW'(1);
               end else begin
                  resp_pc_reg <= resp_pc_reg + STEP;
               end
            end
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ADDR_W + DATA_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect),
      .din   ({resp_pc_reg, imem.rdata}),
      .dout  (fifo_dout),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign dec.valid = !fifo_empty;
   assign dec.instr = fifo_empty ? DATA_W'(INSTR_NOP) : fifo_dout[DATA_W-1:0];
   assign dec.pc    = fifo_empty ? resp_pc_reg : fifo_dout[ADDR_W+DATA_W-1:DATA_W];

endmodule
